// File: rtl/bufarb_pkg.sv
// Shared types and helpers for the bus buffer arbiter: FSM state encoding,
// drive-mode constants and the lowest-requester priority encoder.
package bufarb_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StDrive = 2'd1,
        StTurn  = 2'd2
    } bufarb_state_e;

    localparam int unsigned MODE_REG  = 0;
    localparam int unsigned MODE_FLOW = 1;
    localparam int unsigned MAX_CH    = 8;

    // Index of the lowest set bit; 0 when the vector is empty.
    function automatic logic [2:0] lowest_one(input logic [MAX_CH-1:0] vec);
        logic [2:0] idx;
        idx = '0;
        for (int i = MAX_CH - 1; i >= 0; i--) begin
            if (vec[i]) begin
                idx = 3'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/bus_holding_reg.sv
// Per-channel holding register: captures the channel data slice whenever its
// load enable is high, regardless of bus ownership.
module bus_holding_reg #(
    parameter int unsigned W = 16
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         le_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] data_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            data_q <= '0;
        end else if (le_i) begin
            data_q <= d_i;
        end
    end

    assign q_o = data_q;

endmodule

// File: rtl/bus_buffer_arbiter.sv
// CH sources share one tri-state bus: lowest-index grant, break-before-make
// turnaround of TURN_CYC dead cycles, and saturating contention counting.
module bus_buffer_arbiter
    import bufarb_pkg::*;
#(
    parameter int unsigned CH       = 4,
    parameter int unsigned W        = 16,
    parameter int unsigned TURN_CYC = 1,
    parameter int unsigned MODE     = 0,
    parameter int unsigned CNT_W    = 8
) (
    input  logic              SIM_CLK,
    input  logic              SIM_RST,
    input  logic [CH-1:0]     OE_,
    input  logic [CH-1:0]     LE,
    input  logic [CH*W-1:0]   D,
    output tri   [W-1:0]      BUS,
    output logic [CH-1:0]     ACTIVE,
    output logic              CONFLICT,
    output logic [CNT_W-1:0]  CONFLICT_CNT
);

    localparam int unsigned GW = $clog2(CH);
    localparam int unsigned TW = 2;

    bufarb_state_e  state_q, state_d;
    logic [GW-1:0]  grant_q, grant_d;
    logic [TW-1:0]  turn_q, turn_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [CH-1:0]  req;
    logic [CH-1:0]  grant_mask;
    logic [GW-1:0]  first_idx;
    logic           req_g;
    logic           other_req;
    logic [W-1:0]   hold [CH];
    logic [W-1:0]   drive_data;

    for (genvar c = 0; c < CH; c++) begin : g_hold
        bus_holding_reg #(
            .W (W)
        ) u_hold (
            .clk_i (SIM_CLK),
            .rst_i (SIM_RST),
            .le_i  (LE[c]),
            .d_i   (D[c*W +: W]),
            .q_o   (hold[c])
        );
    end

    // Only a clean 0 requests the bus; X/Z falls through to "not requesting".
    always_comb begin
        req = '0;
        for (int c = 0; c < CH; c++) begin
            if (OE_[c] == 1'b0) begin
                req[c] = 1'b1;
            end
        end
    end

    assign first_idx  = GW'(lowest_one(MAX_CH'(req)));
    assign grant_mask = CH'(1) << grant_q;
    assign req_g      = |(req & grant_mask);
    assign other_req  = |(req & ~grant_mask);

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        turn_d  = turn_q;
        case (state_q)
            StIdle: begin
                if (|req) begin
                    state_d = StDrive;
                    grant_d = first_idx;
                end
            end
            StDrive: begin
                if (!req_g) begin
                    state_d = StTurn;
                    turn_d  = TW'(TURN_CYC - 1);
                end
            end
            StTurn: begin
                // Last dead cycle doubles as the idle arbitration point.
                if (turn_q != '0) begin
                    turn_d = turn_q - 1'b1;
                end else if (|req) begin
                    state_d = StDrive;
                    grant_d = first_idx;
                end else begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign CONFLICT = (state_q == StDrive) && req_g && other_req;

    always_comb begin
        cnt_d = cnt_q;
        if (CONFLICT && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge SIM_CLK or posedge SIM_RST) begin
        if (SIM_RST) begin
            state_q <= StIdle;
            grant_q <= '0;
            turn_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            turn_q  <= turn_d;
            cnt_q   <= cnt_d;
        end
    end

    assign drive_data   = (MODE == MODE_FLOW) ? D[grant_q*W +: W] : hold[grant_q];
    assign BUS          = (state_q == StDrive) ? drive_data : {W{1'bz}};
    assign ACTIVE       = (state_q == StDrive) ? grant_mask : '0;
    assign CONFLICT_CNT = cnt_q;

endmodule

// File: tb/tb_bus_buffer_arbiter.sv
// Bench for bus_buffer_arbiter: a registered-mode instance (TURN_CYC 1) and a
// flow-through instance (TURN_CYC 2, 2-bit counter) share clock and reset.
module tb_bus_buffer_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  oe_a, le_a, oe_b, le_b;
    logic [63:0] d_a, d_b;
    wire  [15:0] bus_a, bus_b;
    logic [3:0]  act_a, act_b;
    logic        conf_a, conf_b;
    logic [7:0]  cnt_a;
    logic [1:0]  cnt_b;

    typedef struct packed {
        logic [3:0]  act;
        logic [15:0] bus;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   errors = 0;
    int   checks = 0;
    logic [15:0] zz;

    always #5 clk = ~clk;

    bus_buffer_arbiter #(
        .CH (4), .W (16), .TURN_CYC (1), .MODE (0), .CNT_W (8)
    ) u_dut_a (
        .SIM_CLK      (clk),
        .SIM_RST      (rst),
        .OE_          (oe_a),
        .LE           (le_a),
        .D            (d_a),
        .BUS          (bus_a),
        .ACTIVE       (act_a),
        .CONFLICT     (conf_a),
        .CONFLICT_CNT (cnt_a)
    );

    bus_buffer_arbiter #(
        .CH (4), .W (16), .TURN_CYC (2), .MODE (1), .CNT_W (2)
    ) u_dut_b (
        .SIM_CLK      (clk),
        .SIM_RST      (rst),
        .OE_          (oe_b),
        .LE           (le_b),
        .D            (d_b),
        .BUS          (bus_b),
        .ACTIVE       (act_b),
        .CONFLICT     (conf_b),
        .CONFLICT_CNT (cnt_b)
    );

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1; oe_a = 4'b0000; oe_b = 4'b1111;
        le_a = '0; le_b = '0; d_a = '0; d_b = '0;
        tick(); tick();
        checks++; if (bus_a !== zz) begin errors++; $display("FAIL reset_bus: got %h want z", bus_a); end
        checks++; if (act_a !== 4'b0000) begin errors++; $display("FAIL reset_active: got %b want 0000", act_a); end
        checks++; if (cnt_a !== 8'd0) begin errors++; $display("FAIL reset_cnt: got %0d want 0", cnt_a); end
        checks++; if (conf_a !== 1'b0) begin errors++; $display("FAIL reset_conflict: got %b want 0", conf_a); end
        rst = 1'b0;
        sb.push_back({4'b0001, 16'h0000});
        tick();
        e = sb.pop_front();
        checks++; if (act_a !== e.act) begin errors++; $display("FAIL reset_grant_active: got %b want %b", act_a, e.act); end
        checks++; if (bus_a !== e.bus) begin errors++; $display("FAIL reset_grant_bus: got %h want %h", bus_a, e.bus); end
        oe_a = 4'b1111;
        tick(); tick();
    endtask

    task automatic test_grant();
        d_a[2*16 +: 16] = 16'h1234; le_a = 4'b0100;
        tick();
        le_a = '0; oe_a = 4'b1011;
        sb.push_back({4'b0100, 16'h1234});
        tick();
        e = sb.pop_front();
        checks++; if (act_a !== e.act) begin errors++; $display("FAIL grant_active: got %b want %b", act_a, e.act); end
        checks++; if (bus_a !== e.bus) begin errors++; $display("FAIL grant_bus: got %h want %h", bus_a, e.bus); end
        checks++; if (conf_a !== 1'b0) begin errors++; $display("FAIL grant_conflict: got %b want 0", conf_a); end
    endtask

    task automatic test_turnaround();
        d_a[1*16 +: 16] = 16'hBEEF; le_a = 4'b0010;
        tick();
        le_a = '0;
        checks++; if (bus_a !== 16'h1234) begin errors++; $display("FAIL turn_hold_bus: got %h want 1234", bus_a); end
        oe_a = 4'b1101;
        tick();
        checks++; if (bus_a !== zz) begin errors++; $display("FAIL turn_dead_bus: got %h want z", bus_a); end
        checks++; if (act_a !== 4'b0000) begin errors++; $display("FAIL turn_dead_active: got %b want 0000", act_a); end
        sb.push_back({4'b0010, 16'hBEEF});
        tick();
        e = sb.pop_front();
        checks++; if (act_a !== e.act) begin errors++; $display("FAIL turn_next_active: got %b want %b", act_a, e.act); end
        checks++; if (bus_a !== e.bus) begin errors++; $display("FAIL turn_next_bus: got %h want %h", bus_a, e.bus); end
        d_a[1*16 +: 16] = 16'hCAFE; le_a = 4'b0010;
        sb.push_back({4'b0010, 16'hCAFE});
        tick();
        le_a = '0;
        e = sb.pop_front();
        checks++; if (bus_a !== e.bus) begin errors++; $display("FAIL load_granted_bus: got %h want %h", bus_a, e.bus); end
    endtask

    task automatic test_contention();
        oe_a = 4'b1111;
        tick(); tick();
        d_a[0 +: 16] = 16'h0F0F; le_a = 4'b0001; oe_a = 4'b1110;
        sb.push_back({4'b0001, 16'h0F0F});
        tick();
        le_a = '0;
        e = sb.pop_front();
        checks++; if (act_a !== e.act) begin errors++; $display("FAIL cont_grant_active: got %b want %b", act_a, e.act); end
        checks++; if (bus_a !== e.bus) begin errors++; $display("FAIL cont_grant_bus: got %h want %h", bus_a, e.bus); end
        oe_a = 4'b0110;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (conf_a !== 1'b1) begin errors++; $display("FAIL cont_pulse[%0d]: got %b want 1", i, conf_a); end
            checks++; if (cnt_a !== 8'(i + 1)) begin errors++; $display("FAIL cont_cnt[%0d]: got %0d want %0d", i, cnt_a, i + 1); end
            checks++; if (bus_a !== 16'h0F0F) begin errors++; $display("FAIL cont_bus[%0d]: got %h want 0f0f", i, bus_a); end
            checks++; if (act_a !== 4'b0001) begin errors++; $display("FAIL cont_active[%0d]: got %b want 0001", i, act_a); end
        end
        oe_a = 4'b1110;
        tick();
        checks++; if (conf_a !== 1'b0) begin errors++; $display("FAIL cont_end_pulse: got %b want 0", conf_a); end
        checks++; if (cnt_a !== 8'd3) begin errors++; $display("FAIL cont_end_cnt: got %0d want 3", cnt_a); end
    endtask

    task automatic test_blip();
        oe_a = 4'b1111;
        tick();
        oe_a = 4'b1110;
        checks++; if (act_a !== 4'b0000) begin errors++; $display("FAIL blip_turn_active: got %b want 0000", act_a); end
        checks++; if (bus_a !== zz) begin errors++; $display("FAIL blip_turn_bus: got %h want z", bus_a); end
        sb.push_back({4'b0001, 16'h0F0F});
        tick();
        e = sb.pop_front();
        checks++; if (act_a !== e.act) begin errors++; $display("FAIL blip_regrant_active: got %b want %b", act_a, e.act); end
        checks++; if (bus_a !== e.bus) begin errors++; $display("FAIL blip_regrant_bus: got %h want %h", bus_a, e.bus); end
    endtask

    task automatic test_flow_through();
        d_b[1*16 +: 16] = 16'hAAAA; oe_b = 4'b1101;
        sb.push_back({4'b0010, 16'hAAAA});
        tick();
        e = sb.pop_front();
        checks++; if (act_b !== e.act) begin errors++; $display("FAIL flow_active: got %b want %b", act_b, e.act); end
        checks++; if (bus_b !== e.bus) begin errors++; $display("FAIL flow_bus: got %h want %h", bus_b, e.bus); end
        d_b[1*16 +: 16] = 16'h5555;
        #1;
        checks++; if (bus_b !== 16'h5555) begin errors++; $display("FAIL flow_follow: got %h want 5555", bus_b); end
        d_b[2*16 +: 16] = 16'h7777; oe_b = 4'b1011;
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++; if (bus_b !== zz) begin errors++; $display("FAIL flow_turn_bus[%0d]: got %h want z", i, bus_b); end
            checks++; if (act_b !== 4'b0000) begin errors++; $display("FAIL flow_turn_active[%0d]: got %b want 0000", i, act_b); end
        end
        sb.push_back({4'b0100, 16'h7777});
        tick();
        e = sb.pop_front();
        checks++; if (act_b !== e.act) begin errors++; $display("FAIL flow_next_active: got %b want %b", act_b, e.act); end
        checks++; if (bus_b !== e.bus) begin errors++; $display("FAIL flow_next_bus: got %h want %h", bus_b, e.bus); end
    endtask

    task automatic test_saturation();
        int want;
        oe_b = 4'b1001;
        for (int i = 0; i < 5; i++) begin
            tick();
            want = (i + 1 > 3) ? 3 : i + 1;
            checks++; if (conf_b !== 1'b1) begin errors++; $display("FAIL sat_pulse[%0d]: got %b want 1", i, conf_b); end
            checks++; if (cnt_b !== 2'(want)) begin errors++; $display("FAIL sat_cnt[%0d]: got %0d want %0d", i, cnt_b, want); end
        end
        oe_b = 4'b1011;
        tick();
        checks++; if (cnt_b !== 2'd3) begin errors++; $display("FAIL sat_hold: got %0d want 3", cnt_b); end
        checks++; if (bus_b !== 16'h7777) begin errors++; $display("FAIL sat_bus: got %h want 7777", bus_b); end
        oe_b = 4'b1111;
        tick();
    endtask

    task automatic test_reset_mid_drive();
        checks++; if (act_a !== 4'b0001) begin errors++; $display("FAIL pre_rst_active: got %b want 0001", act_a); end
        rst = 1'b1;
        #1;
        checks++; if (bus_a !== zz) begin errors++; $display("FAIL rst_mid_bus: got %h want z", bus_a); end
        checks++; if (act_a !== 4'b0000) begin errors++; $display("FAIL rst_mid_active: got %b want 0000", act_a); end
        checks++; if (cnt_a !== 8'd0) begin errors++; $display("FAIL rst_mid_cnt: got %0d want 0", cnt_a); end
        oe_a = 4'b1111;
        tick();
        rst = 1'b0;
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        zz = {16{1'bz}};
        test_reset();
        test_grant();
        test_turnaround();
        test_contention();
        test_blip();
        test_flow_through();
        test_saturation();
        test_reset_mid_drive();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
